// File: rtl/prbs_seq_ctrl_pkg.sv
// Shared definitions for the PRBS symbol-source sequencer, the PRBS generators and the shaping filter.
// Holds the sequencer state encoding, the default timing constants and a clog2 helper.
package prbs_pkg;

  localparam int OS_FACTOR_DEF = 4;
  localparam int SEED_CYC_DEF  = 2;
  localparam int NB_SYMB_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    RUN  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } prbs_state_t;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/prbs_seq_ctrl_os_phase_counter.sv
// Oversampling phase counter: modulo-OS_FACTOR count with synchronous clear and hold.
// o_zero_next flags that the phase about to be registered is 0 (the symbol strobe slot).
module os_phase_counter
  import prbs_pkg::*;
#(
  parameter int OS_FACTOR = OS_FACTOR_DEF,
  parameter int NB_PHASE  = clog2(OS_FACTOR)
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_advance,
  output logic [NB_PHASE-1:0] o_phase,
  output logic                o_zero_next
);

  localparam logic [NB_PHASE-1:0] PHASE_ZERO = {NB_PHASE{1'b0}};
  localparam logic [NB_PHASE-1:0] PHASE_ONE  = NB_PHASE'(1);
  localparam logic [NB_PHASE-1:0] PHASE_LAST = NB_PHASE'(OS_FACTOR - 1);

  logic [NB_PHASE-1:0] phase_next_s;

  // Next phase: clear wins over advance, otherwise hold.
  always_comb begin
    phase_next_s = o_phase;
    if (i_clear) begin
      phase_next_s = PHASE_ZERO;
    end else if (i_advance) begin
      if (o_phase == PHASE_LAST) begin
        phase_next_s = PHASE_ZERO;
      end else begin
        phase_next_s = o_phase + PHASE_ONE;
      end
    end else begin
      phase_next_s = o_phase;
    end
  end

  assign o_zero_next = (phase_next_s == PHASE_ZERO);

  // Phase register.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_phase <= PHASE_ZERO;
    end else begin
      o_phase <= phase_next_s;
    end
  end

endmodule

// File: rtl/prbs_seq_ctrl.sv
// PRBS symbol-source sequencer: reseed/enable control, per-symbol strobe and oversampling phase.
// Define PRBS_BURST_EN to add the burst-length limit (DONE state, i_burst_len and o_done ports).
module prbs_seq_ctrl
  import prbs_pkg::*;
#(
  parameter int OS_FACTOR = OS_FACTOR_DEF,
  parameter int NB_PHASE  = clog2(OS_FACTOR),
  parameter int SEED_CYC  = SEED_CYC_DEF,
  parameter int NB_SYMB   = NB_SYMB_DEF
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_restart,
`ifdef PRBS_BURST_EN
  input  logic [NB_SYMB-1:0]  i_burst_len,
`endif
  output logic                o_prbs_reset,
  output logic                o_prbs_enable,
  output logic                o_valid,
  output logic [NB_PHASE-1:0] o_phase,
  output logic [NB_SYMB-1:0]  o_symb_cnt,
  output logic                o_busy
`ifdef PRBS_BURST_EN
  ,
  output logic                o_done
`endif
);

  localparam int                 NB_SEED   = clog2(SEED_CYC + 1);
  localparam logic [NB_SEED-1:0] SEED_ZERO = {NB_SEED{1'b0}};
  localparam logic [NB_SEED-1:0] SEED_ONE  = NB_SEED'(1);
  localparam logic [NB_SEED-1:0] SEED_LAST = NB_SEED'(SEED_CYC - 1);
  localparam logic [NB_SYMB-1:0] SYMB_ZERO = {NB_SYMB{1'b0}};
  localparam logic [NB_SYMB-1:0] SYMB_ONE  = NB_SYMB'(1);

  prbs_state_t        state_r;
  prbs_state_t        state_next_s;
  logic [NB_SEED-1:0] seed_cnt_r;
  logic [NB_SEED-1:0] seed_cnt_next_s;
  logic               seed_start_s;
  logic               ran_r;
  logic               ran_next_s;
  logic               burst_hit_s;
  logic               phase_clear_s;
  logic               phase_advance_s;
  logic               zero_next_s;
  logic               valid_next_s;
  logic               prbs_reset_next_s;
  logic               prbs_enable_next_s;
  logic               busy_next_s;
  logic [NB_SYMB-1:0] symb_cnt_next_s;

`ifdef PRBS_BURST_EN
  logic [NB_SYMB-1:0] burst_len_r;

  // The registered strobe that brought the count to a non-zero latched length ends the burst.
  always_comb begin
    burst_hit_s = (state_r == RUN) && o_valid && (burst_len_r != SYMB_ZERO) &&
                  (o_symb_cnt == burst_len_r);
  end

  // Burst length is captured whenever a seed period starts.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      burst_len_r <= SYMB_ZERO;
    end else if (seed_start_s) begin
      burst_len_r <= i_burst_len;
    end else begin
      burst_len_r <= burst_len_r;
    end
  end
`else
  assign burst_hit_s = 1'b0;
`endif

  // Next-state logic; restart outranks every other request.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_enable) state_next_s = SEED;
        else          state_next_s = IDLE;
      end
      SEED: begin
        if (i_restart)                     state_next_s = SEED;
        else if (seed_cnt_r == SEED_LAST)  state_next_s = i_enable ? RUN : HOLD;
        else                               state_next_s = SEED;
      end
      RUN: begin
        if (i_restart)        state_next_s = SEED;
        else if (burst_hit_s) state_next_s = DONE;
        else if (!i_enable)   state_next_s = HOLD;
        else                  state_next_s = RUN;
      end
      HOLD: begin
        if (i_restart)     state_next_s = SEED;
        else if (i_enable) state_next_s = RUN;
        else               state_next_s = HOLD;
      end
      DONE: begin
        if (i_restart)      state_next_s = SEED;
        else if (!i_enable) state_next_s = IDLE;
        else                state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath next values: seed timer, phase control, symbol count and output decode.
  always_comb begin
    seed_start_s       = (state_next_s == SEED) && !((state_r == SEED) && !i_restart);
    seed_cnt_next_s    = SEED_ZERO;
    ran_next_s         = ran_r;
    phase_clear_s      = (state_next_s == IDLE) || (state_next_s == SEED);
    phase_advance_s    = 1'b0;
    prbs_reset_next_s  = 1'b0;
    prbs_enable_next_s = 1'b0;
    busy_next_s        = 1'b0;
    if ((state_next_s == SEED) && !seed_start_s) begin
      seed_cnt_next_s = seed_cnt_r + SEED_ONE;
    end else begin
      seed_cnt_next_s = SEED_ZERO;
    end
    // A phase already issued in RUN is never replayed; a fresh seed starts at phase 0 unadvanced.
    if (state_next_s == RUN) begin
      phase_advance_s = (state_r == RUN) || ((state_r == HOLD) && ran_r);
    end else begin
      phase_advance_s = 1'b0;
    end
    if (state_next_s == SEED) begin
      ran_next_s = 1'b0;
    end else if (state_next_s == RUN) begin
      ran_next_s = 1'b1;
    end else begin
      ran_next_s = ran_r;
    end
    case (state_next_s)
      IDLE: begin
        prbs_reset_next_s = 1'b1;
      end
      SEED: begin
        prbs_reset_next_s = 1'b1;
        busy_next_s       = 1'b1;
      end
      RUN: begin
        prbs_enable_next_s = 1'b1;
        busy_next_s        = 1'b1;
      end
      HOLD: begin
        busy_next_s = 1'b1;
      end
      DONE: begin
        busy_next_s = 1'b0;
      end
      default: begin
        prbs_reset_next_s = 1'b1;
      end
    endcase
    valid_next_s = (state_next_s == RUN) && zero_next_s;
    if (seed_start_s) begin
      symb_cnt_next_s = SYMB_ZERO;
    end else if (valid_next_s) begin
      symb_cnt_next_s = o_symb_cnt + SYMB_ONE;
    end else begin
      symb_cnt_next_s = o_symb_cnt;
    end
  end

  os_phase_counter #(
    .OS_FACTOR (OS_FACTOR),
    .NB_PHASE  (NB_PHASE)
  ) u_phase (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_clear     (phase_clear_s),
    .i_advance   (phase_advance_s),
    .o_phase     (o_phase),
    .o_zero_next (zero_next_s)
  );

  // State, seed timer and registered outputs.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_r       <= IDLE;
      seed_cnt_r    <= SEED_ZERO;
      ran_r         <= 1'b0;
      o_prbs_reset  <= 1'b1;
      o_prbs_enable <= 1'b0;
      o_valid       <= 1'b0;
      o_symb_cnt    <= SYMB_ZERO;
      o_busy        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      seed_cnt_r    <= seed_cnt_next_s;
      ran_r         <= ran_next_s;
      o_prbs_reset  <= prbs_reset_next_s;
      o_prbs_enable <= prbs_enable_next_s;
      o_valid       <= valid_next_s;
      o_symb_cnt    <= symb_cnt_next_s;
      o_busy        <= busy_next_s;
    end
  end

`ifdef PRBS_BURST_EN
  // Burst-complete flag mirrors residency in DONE.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_done <= 1'b0;
    end else begin
      o_done <= (state_next_s == DONE);
    end
  end
`endif

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Directed bench for prbs_seq_ctrl (OS_FACTOR=4, SEED_CYC=2, NB_SYMB=4 so the count wraps quickly).
// The burst scenario is compiled in when PRBS_BURST_EN is defined.
module tb_prbs_seq_ctrl;

  logic       clock;
  logic       i_reset;
  logic       i_enable;
  logic       i_restart;
  logic       o_prbs_reset;
  logic       o_prbs_enable;
  logic       o_valid;
  logic [1:0] o_phase;
  logic [3:0] o_symb_cnt;
  logic       o_busy;
  logic [9:0] obs_s;
  int         checks;
  int         errors;
`ifdef PRBS_BURST_EN
  logic [3:0] i_burst_len;
  logic       o_done;
`endif

  // {prbs_reset, prbs_enable, valid, busy, phase[1:0], symb_cnt[3:0]}
  assign obs_s = {o_prbs_reset, o_prbs_enable, o_valid, o_busy, o_phase, o_symb_cnt};

  prbs_seq_ctrl #(
    .OS_FACTOR (4),
    .NB_PHASE  (2),
    .SEED_CYC  (2),
    .NB_SYMB   (4)
  ) dut (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_restart     (i_restart),
`ifdef PRBS_BURST_EN
    .i_burst_len   (i_burst_len),
`endif
    .o_prbs_reset  (o_prbs_reset),
    .o_prbs_enable (o_prbs_enable),
    .o_valid       (o_valid),
    .o_phase       (o_phase),
    .o_symb_cnt    (o_symb_cnt),
    .o_busy        (o_busy)
`ifdef PRBS_BURST_EN
    ,
    .o_done        (o_done)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    i_reset   = 1'b1;
    i_enable  = 1'b0;
    i_restart = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (obs_s !== 10'b1000_00_0000) begin
      errors++;
      $display("FAIL reset_state: got %b want 1000000000", obs_s);
    end
`ifdef PRBS_BURST_EN
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", o_done);
    end
`endif
    i_reset = 1'b0;
    tick();
    checks++;
    if (obs_s !== 10'b1000_00_0000) begin
      errors++;
      $display("FAIL idle_no_enable: got %b want 1000000000", obs_s);
    end
  endtask

  task automatic test_startup();
    logic [9:0] rows [13];
    rows = '{10'b1001_00_0000, 10'b1001_00_0000, 10'b0111_00_0001,
             10'b0101_01_0001, 10'b0101_10_0001, 10'b0101_11_0001,
             10'b0111_00_0010, 10'b0101_01_0010, 10'b0101_10_0010,
             10'b0101_11_0010, 10'b0111_00_0011, 10'b0101_01_0011,
             10'b0101_10_0011};
    i_enable = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (obs_s !== rows[i]) begin
        errors++;
        $display("FAIL startup[%0d]: got %b want %b", i, obs_s, rows[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [9:0] exp_v;
    i_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_s !== 10'b0001_10_0011) begin
        errors++;
        $display("FAIL hold[%0d]: got %b want 0001100011", i, obs_s);
      end
    end
    i_enable = 1'b1;
    tick();
    checks++;
    if (obs_s !== 10'b0101_11_0011) begin
      errors++;
      $display("FAIL resume_ph3: got %b want 0101110011", obs_s);
    end
    tick();
    checks++;
    if (obs_s !== 10'b0111_00_0100) begin
      errors++;
      $display("FAIL resume_strobe: got %b want 0111000100", obs_s);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_v = {1'b0, 1'b1, (k % 4 == 0), 1'b1, 2'(k % 4), 4'(4 + k / 4)};
      checks++;
      if (obs_s !== exp_v) begin
        errors++;
        $display("FAIL run_to_7[%0d]: got %b want %b", k, obs_s, exp_v);
      end
    end
  endtask

  task automatic test_restart();
    logic [9:0] rows [3];
    rows = '{10'b1001_00_0000, 10'b1001_00_0000, 10'b0111_00_0001};
    i_restart = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      i_restart = 1'b0;
      checks++;
      if (obs_s !== rows[i]) begin
        errors++;
        $display("FAIL restart[%0d]: got %b want %b", i, obs_s, rows[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    tick();
    tick();
    checks++;
    if (obs_s !== 10'b0101_10_0001) begin
      errors++;
      $display("FAIL pre_reset_run: got %b want 0101100001", obs_s);
    end
    #2;
    i_reset = 1'b1;
    #1;
    checks++;
    if (obs_s !== 10'b1000_00_0000) begin
      errors++;
      $display("FAIL async_reset: got %b want 1000000000", obs_s);
    end
    tick();
    i_reset   = 1'b0;
    i_enable  = 1'b0;
    i_restart = 1'b1;
    tick();
    i_restart = 1'b0;
    checks++;
    if (obs_s !== 10'b1000_00_0000) begin
      errors++;
      $display("FAIL idle_restart_ignored: got %b want 1000000000", obs_s);
    end
  endtask

  task automatic test_seed_hold();
    logic [9:0] rows [6];
    logic       ens  [6];
    rows = '{10'b1001_00_0000, 10'b1001_00_0000, 10'b0001_00_0000,
             10'b0001_00_0000, 10'b0111_00_0001, 10'b0101_01_0001};
    ens  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      i_enable = ens[i];
      tick();
      checks++;
      if (obs_s !== rows[i]) begin
        errors++;
        $display("FAIL seed_hold[%0d]: got %b want %b", i, obs_s, rows[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [9:0] exp_v;
    i_restart = 1'b1;
    tick();
    i_restart = 1'b0;
    tick();
    tick();
    checks++;
    if (obs_s !== 10'b0111_00_0001) begin
      errors++;
      $display("FAIL wrap_start: got %b want 0111000001", obs_s);
    end
    for (int k = 1; k <= 68; k++) begin
      tick();
      exp_v = {1'b0, 1'b1, (k % 4 == 0), 1'b1, 2'(k % 4), 4'(1 + k / 4)};
      checks++;
      if (obs_s !== exp_v) begin
        errors++;
        $display("FAIL wrap[%0d]: got %b want %b", k, obs_s, exp_v);
      end
    end
`ifdef PRBS_BURST_EN
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL unlimited_no_done: got %b want 0", o_done);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [9:0] rows [4];
    rows = '{10'b1001_00_0000, 10'b1001_00_0000, 10'b1001_00_0000, 10'b0111_00_0001};
    i_restart = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) i_restart = 1'b0;
      checks++;
      if (obs_s !== rows[i]) begin
        errors++;
        $display("FAIL restart_twice[%0d]: got %b want %b", i, obs_s, rows[i]);
      end
    end
  endtask

`ifdef PRBS_BURST_EN
  task automatic test_burst();
    int pulses;
    i_burst_len = 4'd5;
    for (int b = 0; b < 2; b++) begin
      i_restart = 1'b1;
      tick();
      i_restart   = 1'b0;
      i_burst_len = 4'd3;
      pulses      = 0;
      for (int c = 0; c < 60 && o_done !== 1'b1; c++) begin
        tick();
        if (o_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 5) begin
        errors++;
        $display("FAIL burst%0d_pulses: got %0d want 5", b, pulses);
      end
      checks++;
      if ({o_done, obs_s} !== 11'b1_0000_00_0101) begin
        errors++;
        $display("FAIL burst%0d_done: got %b want 10000000101", b, {o_done, obs_s});
      end
      tick();
      tick();
      checks++;
      if ({o_done, obs_s} !== 11'b1_0000_00_0101) begin
        errors++;
        $display("FAIL burst%0d_done_hold: got %b want 10000000101", b, {o_done, obs_s});
      end
      i_burst_len = 4'd5;
    end
    i_enable = 1'b0;
    tick();
    checks++;
    if ({o_done, o_prbs_reset, o_prbs_enable, o_valid, o_busy} !== 5'b01000) begin
      errors++;
      $display("FAIL done_to_idle: got %b want 01000",
               {o_done, o_prbs_reset, o_prbs_enable, o_valid, o_busy});
    end
    i_burst_len = 4'd0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
`ifdef PRBS_BURST_EN
    i_burst_len = 4'd0;
`endif
    test_reset();
    test_startup();
    test_hold();
    test_restart();
    test_async_reset();
    test_seed_hold();
    test_wrap();
    test_back_to_back();
`ifdef PRBS_BURST_EN
    test_burst();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
